stack_arbiter: RTL and testbench

- Shares one stack instance between two requesters, client A and client B, e.g. the operator path and the operand/evaluation path of the infix-to-postfix calculator.
- Arbitrates push/pop transactions round-robin and runs one downstream stack transaction at a time.
- Tracks stack occupancy, so overflow and underflow requests are rejected with an error response and never reach the stack.

---
 rtl/stack_arbiter.sv | 136 +++++++++++++
 tb/tb_stack_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-client round-robin front end for a single LIFO stack.
// Occupancy is tracked locally so overflow/underflow requests are answered with an error and never reach the stack.
module stack_arbiter #(
   parameter int DW    = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             A_PUSH_STB,
   input  logic [DW-1:0]    A_PUSH_DAT,
   output logic             A_PUSH_ACK,
   input  logic             A_POP_STB,
   output logic             A_POP_ACK,
   output logic [DW-1:0]    A_POP_DAT,
   output logic             A_ERR,
   input  logic             B_PUSH_STB,
   input  logic [DW-1:0]    B_PUSH_DAT,
   output logic             B_PUSH_ACK,
   input  logic             B_POP_STB,
   output logic             B_POP_ACK,
   output logic [DW-1:0]    B_POP_DAT,
   output logic             B_ERR,
   output logic             PUSH_STB,
   output logic [DW-1:0]    PUSH_DAT,
   input  logic             PUSH_ACK,
   output logic             POP_STB,
   input  logic [DW-1:0]    POP_DAT,
   input  logic             POP_ACK,
   output logic [CNT_W-1:0] COUNT,
   output logic             FULL,
   output logic             EMPTY,
   output logic             BUSY
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [1:0]       state;
   logic             last_b;
   logic             gnt_b;
   logic             op_push;
   logic             a_req, b_req, sel_b, sel_push, sel_err;
   logic [DW-1:0]    sel_dat;
   logic             idle_err, issue_done, resp_fire, resp_b, resp_push;
   logic [DW-1:0]    resp_dat;
   logic [CNT_W-1:0] cnt_nxt;

   // Grant decode: push outranks pop within a client; on conflict the client not served last wins.
   always_comb begin
      a_req      = A_PUSH_STB | A_POP_STB;
      b_req      = B_PUSH_STB | B_POP_STB;
      sel_b      = b_req & (~a_req | ~last_b);
      sel_push   = sel_b ? B_PUSH_STB : A_PUSH_STB;
      sel_dat    = sel_b ? B_PUSH_DAT : A_PUSH_DAT;
      sel_err    = sel_push ? FULL : EMPTY;
      idle_err   = (state == IDLE) & (a_req | b_req) & sel_err;
      issue_done = (state == ISSUE) & (op_push ? PUSH_ACK : POP_ACK);
      resp_fire  = idle_err | issue_done;
      resp_b     = (state == IDLE) ? sel_b : gnt_b;
      resp_push  = (state == IDLE) ? sel_push : op_push;
      resp_dat   = (issue_done & ~op_push) ? POP_DAT : '0;
      cnt_nxt    = op_push ? COUNT + CNT_W'(1) : COUNT - CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_b     <= 1'b1;
         gnt_b      <= 1'b0;
         op_push    <= 1'b0;
         A_PUSH_ACK <= 1'b0;
         A_POP_ACK  <= 1'b0;
         A_POP_DAT  <= '0;
         A_ERR      <= 1'b0;
         B_PUSH_ACK <= 1'b0;
         B_POP_ACK  <= 1'b0;
         B_POP_DAT  <= '0;
         B_ERR      <= 1'b0;
         PUSH_STB   <= 1'b0;
         PUSH_DAT   <= '0;
         POP_STB    <= 1'b0;
         COUNT      <= '0;
         FULL       <= 1'b0;
         EMPTY      <= 1'b1;
         BUSY       <= 1'b0;
      end else begin
         // Client responses are single-cycle pulses raised on entry to RESP.
         A_PUSH_ACK <= resp_fire & ~resp_b & resp_push;
         A_POP_ACK  <= resp_fire & ~resp_b & ~resp_push;
         B_PUSH_ACK <= resp_fire & resp_b & resp_push;
         B_POP_ACK  <= resp_fire & resp_b & ~resp_push;
         A_ERR      <= idle_err & ~resp_b;
         B_ERR      <= idle_err & resp_b;
         A_POP_DAT  <= (resp_fire & ~resp_b) ? resp_dat : '0;
         B_POP_DAT  <= (resp_fire & resp_b) ? resp_dat : '0;
         case (state)
            IDLE: begin
               if (a_req | b_req) begin
                  gnt_b   <= sel_b;
                  op_push <= sel_push;
                  BUSY    <= 1'b1;
                  if (a_req & b_req) last_b <= sel_b;
                  if (sel_err) begin
                     state <= RESP;
                  end else begin
                     state    <= ISSUE;
                     PUSH_STB <= sel_push;
                     POP_STB  <= ~sel_push;
                     PUSH_DAT <= sel_push ? sel_dat : '0;
                  end
               end
            end
            ISSUE: begin
               if (issue_done) begin
                  PUSH_STB <= 1'b0;
                  POP_STB  <= 1'b0;
                  COUNT    <= cnt_nxt;
                  FULL     <= (cnt_nxt == DEPTH_C);
                  EMPTY    <= (cnt_nxt == '0);
                  state    <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: stack and client models, a transaction-level reference checked every cycle, directed and random traffic.
module tb_stack_arbiter;
   localparam int DW = 32, DEPTH = 16, CNT_W = 5;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic a_push_stb = 1'b0, a_pop_stb = 1'b0, b_push_stb = 1'b0, b_pop_stb = 1'b0;
   logic [DW-1:0] a_push_dat = '0, b_push_dat = '0;
   logic a_push_ack, a_pop_ack, a_err, b_push_ack, b_pop_ack, b_err;
   logic [DW-1:0] a_pop_dat, b_pop_dat, push_dat;
   logic push_stb, pop_stb, full, empty, busy;
   logic [CNT_W-1:0] count;
   logic push_ack_s = 1'b0, pop_ack_s = 1'b0;
   logic [DW-1:0] pop_dat_s = '0;

   stack_arbiter #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .A_PUSH_STB(a_push_stb), .A_PUSH_DAT(a_push_dat), .A_PUSH_ACK(a_push_ack),
      .A_POP_STB(a_pop_stb), .A_POP_ACK(a_pop_ack), .A_POP_DAT(a_pop_dat), .A_ERR(a_err),
      .B_PUSH_STB(b_push_stb), .B_PUSH_DAT(b_push_dat), .B_PUSH_ACK(b_push_ack),
      .B_POP_STB(b_pop_stb), .B_POP_ACK(b_pop_ack), .B_POP_DAT(b_pop_dat), .B_ERR(b_err),
      .PUSH_STB(push_stb), .PUSH_DAT(push_dat), .PUSH_ACK(push_ack_s),
      .POP_STB(pop_stb), .POP_DAT(pop_dat_s), .POP_ACK(pop_ack_s),
      .COUNT(count), .FULL(full), .EMPTY(empty), .BUSY(busy)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Attached stack: acknowledges after ack_dly strobe cycles.
   logic [DW-1:0] smem [DEPTH];
   int sp = 0, wcnt = 0, ack_dly = 1;
   always @(posedge CLK) begin
      push_ack_s <= 1'b0;
      pop_ack_s  <= 1'b0;
      if (RST) begin
         sp   <= 0;
         wcnt <= 0;
      end else if ((push_stb && !push_ack_s) || (pop_stb && !pop_ack_s)) begin
         if (wcnt + 1 >= ack_dly) begin
            wcnt <= 0;
            if (push_stb) begin
               if (sp < DEPTH) smem[sp[3:0]] <= push_dat;
               sp <= sp + 1;
               push_ack_s <= 1'b1;
            end else begin
               pop_dat_s <= (sp > 0) ? smem[4'(sp - 1)] : 32'hDEAD_BEEF;
               sp <= sp - 1;
               pop_ack_s <= 1'b1;
            end
         end else begin
            wcnt <= wcnt + 1;
         end
      end
   end

   int n_tests = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Event counters observed on the downstream side.
   int push_rises = 0, pop_rises = 0, hold_cnt = 0, dat_chg = 0, busy_cnt = 0, a_ack_cnt = 0;
   initial begin
      logic pp, pq;
      logic [DW-1:0] pd;
      pp = 1'b0; pq = 1'b0; pd = '0;
      forever begin
         @(negedge CLK);
         if (push_stb && !pp) push_rises++;
         if (pop_stb && !pq) pop_rises++;
         if (push_stb && !push_ack_s) hold_cnt++;
         if (push_stb && pp && push_dat !== pd) dat_chg++;
         if (busy) busy_cnt++;
         if (a_push_ack || a_pop_ack) a_ack_cnt++;
         pp = push_stb; pq = pop_stb; pd = push_dat;
      end
   end

   // Reference model: a queue for the stack plus one transaction in flight.
   logic [DW-1:0] mq[$];
   bit m_on = 0, m_last_b = 1, m_txn = 0, m_issue = 0, t_b = 0, t_push = 0, ra, rb;
   logic [DW-1:0] t_dat = '0, e_rdat = '0;
   bit e_apa, e_apo, e_bpa, e_bpo, e_aerr, e_berr, e_pstb, e_postb, e_busy;
   int e_cnt = 0, t_age = 0;

   task automatic exp_resp(input bit err, input logic [DW-1:0] d);
      e_apa = !t_b && t_push;  e_apo = !t_b && !t_push;
      e_bpa = t_b && t_push;   e_bpo = t_b && !t_push;
      e_aerr = !t_b && err;    e_berr = t_b && err;
      e_rdat = d;
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         if (m_on) begin
            chk("a_push_ack", 64'(a_push_ack), 64'(e_apa));
            chk("a_pop_ack", 64'(a_pop_ack), 64'(e_apo));
            chk("b_push_ack", 64'(b_push_ack), 64'(e_bpa));
            chk("b_pop_ack", 64'(b_pop_ack), 64'(e_bpo));
            chk("a_err", 64'(a_err), 64'(e_aerr));
            chk("b_err", 64'(b_err), 64'(e_berr));
            if (e_apo) chk("a_pop_dat", 64'(a_pop_dat), 64'(e_rdat));
            if (e_bpo) chk("b_pop_dat", 64'(b_pop_dat), 64'(e_rdat));
            chk("push_stb", 64'(push_stb), 64'(e_pstb));
            chk("pop_stb", 64'(pop_stb), 64'(e_postb));
            if (e_pstb) chk("push_dat", 64'(push_dat), 64'(t_dat));
            chk("count", 64'(count), 64'(e_cnt));
            chk("full", 64'(full), 64'(e_cnt == DEPTH));
            chk("empty", 64'(empty), 64'(e_cnt == 0));
            chk("busy", 64'(busy), 64'(e_busy));
         end
         {e_apa, e_apo, e_bpa, e_bpo, e_aerr, e_berr, e_pstb, e_postb} = '0;
         if (RST) begin
            mq.delete();
            m_on = 1; m_last_b = 1; m_txn = 0; m_issue = 0; e_busy = 0;
         end else if (m_on) begin
            if (!m_txn) begin
               ra = a_push_stb || a_pop_stb;
               rb = b_push_stb || b_pop_stb;
               e_busy = 0;
               if (ra || rb) begin
                  t_b = rb && (!ra || !m_last_b);
                  if (ra && rb) m_last_b = t_b;
                  t_push = t_b ? b_push_stb : a_push_stb;
                  t_dat = t_b ? b_push_dat : a_push_dat;
                  m_txn = 1; t_age = 0; e_busy = 1;
                  if (t_push ? (mq.size() == DEPTH) : (mq.size() == 0)) exp_resp(1'b1, '0);
                  else begin
                     m_issue = 1; e_pstb = t_push; e_postb = !t_push;
                  end
               end
            end else if (m_issue) begin
               t_age++;
               if (t_push ? push_ack_s : pop_ack_s) begin
                  m_issue = 0;
                  if (t_push) begin
                     mq.push_back(t_dat);
                     exp_resp(1'b0, '0);
                  end else begin
                     exp_resp(1'b0, mq.pop_back());
                  end
               end else begin
                  e_pstb = t_push; e_postb = !t_push;
               end
               if (t_age > 60) begin
                  n_tests++; n_fail++;
                  $display("FAIL stack_txn_timeout: %0d cycles without stack ack, required completion", t_age);
                  m_issue = 0; m_txn = 0; e_busy = 0;
               end
            end else begin
               m_txn = 0; e_busy = 0;
            end
         end
         e_cnt = mq.size();
      end
   end

   // Client protocol: hold strobes until the matching ack, drop on the edge closing the ack cycle.
   task automatic do_req(input bit b, input bit push, input bit pop, input logic [DW-1:0] d,
                         output logic [DW-1:0] got_dat, output bit got_err, output int lat, output int ack_cyc);
      bit pp, pq;
      int n;
      pp = push; pq = pop; n = 0;
      got_dat = '0; got_err = 0; lat = -1; ack_cyc = -1;
      if (b) begin b_push_dat = d; b_push_stb = push; b_pop_stb = pop; end
      else begin a_push_dat = d; a_push_stb = push; a_pop_stb = pop; end
      while ((pp || pq) && n < 300) begin
         @(negedge CLK);
         n++;
         if (pp && (b ? b_push_ack : a_push_ack)) begin
            pp = 0; got_err = b ? b_err : a_err; ack_cyc = cyc;
            if (lat < 0) lat = n - 1;
            @(posedge CLK); #1;
            if (b) b_push_stb = 1'b0; else a_push_stb = 1'b0;
         end else if (pq && (b ? b_pop_ack : a_pop_ack)) begin
            pq = 0; got_err = b ? b_err : a_err; ack_cyc = cyc;
            got_dat = b ? b_pop_dat : a_pop_dat;
            if (lat < 0) lat = n - 1;
            @(posedge CLK); #1;
            if (b) b_pop_stb = 1'b0; else a_pop_stb = 1'b0;
         end
      end
      if (pp || pq) begin
         n_tests++; n_fail++;
         $display("FAIL client_ack_timeout side=%0d: no ack in %0d cycles, required an ack", b, n);
         if (b) begin b_push_stb = 1'b0; b_pop_stb = 1'b0; end
         else begin a_push_stb = 1'b0; a_pop_stb = 1'b0; end
         @(posedge CLK); #1;
      end
   endtask

   task automatic rand_req(input bit b);
      int g, r;
      logic [DW-1:0] d;
      bit e;
      int l, c;
      g = $urandom_range(0, 3);
      if (g > 0) begin repeat (g) @(posedge CLK); #1; end
      r = $urandom_range(0, 9);
      if (!b) do_req(b, (r < 6) || (r == 9), r >= 6, $urandom, d, e, l, c);
      else    do_req(b, (r < 3) || (r == 9), r >= 3, $urandom, d, e, l, c);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   bit rnd_done = 0;
   initial begin
      logic [DW-1:0] d1, d2;
      bit e1, e2;
      int l1, l2, c1, c2, base, base2, base3, base4;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_push_stb", 64'(push_stb), 64'd0);

      // Basic LIFO order through client A
      base = push_rises;
      do_req(0, 1, 0, 32'h11, d1, e1, l1, c1);
      chk("t1_push_lat", 64'(l1), 64'd3);
      chk("t1_cnt1", 64'(count), 64'd1);
      do_req(0, 1, 0, 32'h22, d1, e1, l1, c1);
      chk("t1_cnt2", 64'(count), 64'd2);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t1_pop1", 64'(d1), 64'h22);
      chk("t1_cnt3", 64'(count), 64'd1);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t1_pop2", 64'(d1), 64'h11);
      chk("t1_err", 64'(e1), 64'd0);
      chk("t1_cnt4", 64'(count), 64'd0);
      chk("t1_push_stb_count", 64'(push_rises - base), 64'd2);

      // Simultaneous pushes, then a second conflict
      fork
         do_req(0, 1, 0, 32'hAA, d1, e1, l1, c1);
         do_req(1, 1, 0, 32'hBB, d2, e2, l2, c2);
      join
      chk("t2_a_first", 64'(c1 < c2), 64'd1);
      chk("t2_b_gap", 64'(c2 - c1), 64'd4);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t2_pop_bb", 64'(d1), 64'hBB);
      fork
         do_req(0, 1, 0, 32'hA1, d1, e1, l1, c1);
         do_req(1, 1, 0, 32'hB1, d2, e2, l2, c2);
      join
      chk("t2_b_first", 64'(c2 < c1), 64'd1);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t2_pop_a1", 64'(d1), 64'hA1);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t2_pop_b1", 64'(d1), 64'hB1);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t2_pop_aa", 64'(d1), 64'hAA);

      // Underflow from B
      base = pop_rises;
      do_req(1, 0, 1, 0, d2, e2, l2, c2);
      chk("t3_err", 64'(e2), 64'd1);
      chk("t3_lat", 64'(l2), 64'd1);
      chk("t3_dat", 64'(d2), 64'd0);
      chk("t3_no_pop_stb", 64'(pop_rises - base), 64'd0);
      chk("t3_cnt", 64'(count), 64'd0);

      // Fill to capacity, then overflow
      for (int i = 1; i <= DEPTH; i++) do_req(0, 1, 0, 32'(i), d1, e1, l1, c1);
      chk("t4_full", 64'(full), 64'd1);
      chk("t4_cnt", 64'(count), 64'd16);
      base = push_rises;
      do_req(0, 1, 0, 32'h99, d1, e1, l1, c1);
      chk("t4_ovf_err", 64'(e1), 64'd1);
      chk("t4_ovf_lat", 64'(l1), 64'd1);
      chk("t4_no_push_stb", 64'(push_rises - base), 64'd0);
      chk("t4_cnt_hold", 64'(count), 64'd16);
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t4_pop16", 64'(d1), 64'd16);
      for (int i = 0; i < DEPTH - 1; i++) do_req(1, 0, 1, 0, d2, e2, l2, c2);
      chk("t4_last_pop", 64'(d2), 64'd1);
      chk("t4_empty", 64'(empty), 64'd1);

      // Slow stack acknowledge
      ack_dly = 5;
      base = hold_cnt; base2 = dat_chg; base3 = busy_cnt; base4 = a_ack_cnt;
      do_req(0, 1, 0, 32'h55, d1, e1, l1, c1);
      chk("t5_hold", 64'(hold_cnt - base), 64'd5);
      chk("t5_dat_stable", 64'(dat_chg - base2), 64'd0);
      chk("t5_busy", 64'(busy_cnt - base3), 64'd7);
      chk("t5_one_ack", 64'(a_ack_cnt - base4), 64'd1);
      chk("t5_lat", 64'(l1), 64'd7);

      // Reset during ISSUE abandons the transaction
      ack_dly = 1;
      do_req(0, 0, 1, 0, d1, e1, l1, c1);
      chk("t6_pre_pop", 64'(d1), 64'h55);
      do_req(0, 1, 0, 32'h44, d1, e1, l1, c1);
      ack_dly = 5;
      base = a_ack_cnt;
      a_push_dat = 32'h77; a_push_stb = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk("t6_in_issue", 64'(push_stb), 64'd1);
      RST = 1'b1; a_push_stb = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b0;
      chk("t6_stb_drop", 64'(push_stb), 64'd0);
      chk("t6_cnt", 64'(count), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);
      repeat (4) @(posedge CLK);
      #1;
      chk("t6_no_ack", 64'(a_ack_cnt - base), 64'd0);
      ack_dly = 1;
      do_req(0, 1, 0, 32'h33, d1, e1, l1, c1);
      chk("t6_after_err", 64'(e1), 64'd0);
      chk("t6_after_lat", 64'(l1), 64'd3);
      chk("t6_after_cnt", 64'(count), 64'd1);

      // Random concurrent traffic against the reference model
      fork
         begin
            while (!rnd_done) begin
               repeat (7) @(posedge CLK);
               #1 ack_dly = $urandom_range(1, 3);
            end
         end
      join_none
      fork
         begin for (int i = 0; i < 150; i++) rand_req(0); end
         begin for (int j = 0; j < 150; j++) rand_req(1); end
      join
      rnd_done = 1;
      ack_dly = 1;
      repeat (10) @(posedge CLK);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
